// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer for an out-of-order core.
//
// Each entry holds valid, done, has_rd and pd_old. Dispatch allocates at the
// tail. Three functional units (alu, b, mem) mark entries done. The head
// retires in order, one entry per cycle, and returns pd_old to the freelist.
// A branch mispredict discards every entry younger than the branch.
//
// Ports:
//   clk, reset (async, active-low)
//   alloc_valid/alloc_ready/alloc_has_rd/alloc_pd_old/alloc_tag  - dispatch
//   {alu,b,mem}_done/{alu,b,mem}_tag                            - completions
//   mispredict/mispredict_tag                                   - branch flush
//   retire_valid/retire_tag/retire_has_rd/retire_pd_old         - retirement
//   count                                                       - occupancy
//   retired_count (only with ROB_PERF_CNT_EN defined)           - retire counter
//
// Optional feature macro: ROB_PERF_CNT_EN adds the 32-bit retired_count output.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 7,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_has_rd,
  input  logic [PREG_W-1:0] alloc_pd_old,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              alu_done,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic              b_done,
  input  logic [TAG_W-1:0]  b_tag,
  input  logic              mem_done,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              retire_valid,
  output logic [TAG_W-1:0]  retire_tag,
  output logic              retire_has_rd,
  output logic [PREG_W-1:0] retire_pd_old,
  output logic [TAG_W:0]    count
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]       retired_count
`endif
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  has_rd_q;
  logic [PREG_W-1:0] pd_old_q [DEPTH];

  logic              alloc_fire;
  logic              mp_fire;
  logic [TAG_W-1:0]  mp_off;
  logic [TAG_W-1:0]  keep_mod;
  logic [TAG_W:0]    keep;
  logic [DEPTH-1:0]  flush;
  logic [DEPTH-1:0]  done_set;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  done_d;
  logic [TAG_W:0]    count_d;
  logic [TAG_W-1:0]  tail_d;

  // Control and per-entry next state
  always_comb begin
    alloc_ready  = (count < DEPTH_C) && !mispredict;
    alloc_fire   = alloc_valid && alloc_ready;
    retire_valid = (count != '0) && valid_q[head] && done_q[head];
    mp_fire      = mispredict && valid_q[mispredict_tag];

    // Age is measured as distance from head; anything farther than the
    // branch is younger and gets flushed.
    mp_off = mispredict_tag - head;
    flush  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mp_fire && ((TAG_W'(i) - head) > mp_off)) flush[i] = 1'b1;
    end

    done_set = '0;
    if (alu_done && valid_q[alu_tag]) done_set[alu_tag] = 1'b1;
    if (b_done   && valid_q[b_tag])   done_set[b_tag]   = 1'b1;
    if (mem_done && valid_q[mem_tag]) done_set[mem_tag] = 1'b1;

    valid_d = valid_q & ~flush;
    done_d  = (done_q | done_set) & ~flush;
    if (retire_valid) begin
      valid_d[head] = 1'b0;
      done_d[head]  = 1'b0;
    end
    if (alloc_fire) begin
      valid_d[tail] = 1'b1;
      done_d[tail]  = 1'b0;
    end

    // Surviving span is head..branch inclusive; a zero modulo result can
    // only mean the branch is the youngest entry of a full buffer.
    keep_mod = mp_off + TAG_W'(1);
    keep     = (keep_mod == '0) ? DEPTH_C : {1'b0, keep_mod};

    if (mp_fire) begin
      count_d = keep - (TAG_W+1)'(retire_valid);
      tail_d  = mispredict_tag + TAG_W'(1);
    end else begin
      count_d = count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_valid);
      tail_d  = alloc_fire ? tail + TAG_W'(1) : tail;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head    <= retire_valid ? head + TAG_W'(1) : head;
      tail    <= tail_d;
      count   <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload only matters while valid, so it is written on allocation alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      has_rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) pd_old_q[i] <= '0;
    end else if (alloc_fire) begin
      has_rd_q[tail] <= alloc_has_rd;
      pd_old_q[tail] <= alloc_pd_old;
    end
  end

  always_comb begin
    alloc_tag = tail;
    if (count == '0) begin
      retire_tag    = '0;
      retire_has_rd = 1'b0;
      retire_pd_old = '0;
    end else begin
      retire_tag    = head;
      retire_has_rd = has_rd_q[head];
      retire_pd_old = pd_old_q[head];
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_count <= '0;
    else if (retire_valid) retired_count <= retired_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (DEPTH=16, PREG_W=7).
module tb_reorder_buffer;

  logic       clk;
  logic       reset;
  logic       alloc_valid;
  logic       alloc_ready;
  logic       alloc_has_rd;
  logic [6:0] alloc_pd_old;
  logic [3:0] alloc_tag;
  logic       alu_done, b_done, mem_done;
  logic [3:0] alu_tag, b_tag, mem_tag;
  logic       mispredict;
  logic [3:0] mispredict_tag;
  logic       retire_valid;
  logic [3:0] retire_tag;
  logic       retire_has_rd;
  logic [6:0] retire_pd_old;
  logic [4:0] count;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] retired_count;
`endif

  int errors = 0;
  int checks = 0;

  reorder_buffer #(.DEPTH(16), .PREG_W(7)) dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_has_rd   (alloc_has_rd),
    .alloc_pd_old   (alloc_pd_old),
    .alloc_tag      (alloc_tag),
    .alu_done       (alu_done),
    .alu_tag        (alu_tag),
    .b_done         (b_done),
    .b_tag          (b_tag),
    .mem_done       (mem_done),
    .mem_tag        (mem_tag),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .retire_valid   (retire_valid),
    .retire_tag     (retire_tag),
    .retire_has_rd  (retire_has_rd),
    .retire_pd_old  (retire_pd_old),
    .count          (count)
`ifdef ROB_PERF_CNT_EN
    ,
    .retired_count  (retired_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid = 0; alloc_has_rd = 0; alloc_pd_old = '0;
    alu_done = 0; b_done = 0; mem_done = 0;
    alu_tag = '0; b_tag = '0; mem_tag = '0;
    mispredict = 0; mispredict_tag = '0;
  endtask

  // Called just after a rising edge; reset pulse lies well between edges.
  task automatic do_reset();
    clear_inputs();
    reset = 0;
    #1;
    reset = 1;
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_retire_tag", retire_tag, 0);
    #1 reset = 1;
    tick();

    // Fill with no completions
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1; alloc_has_rd = 1; alloc_pd_old = 7'(i);
      chk("fill_tag", alloc_tag, i);
      chk("fill_ready", alloc_ready, 1);
      tick();
    end
    chk("full_count", count, 16);
    chk("full_ready", alloc_ready, 0);
    chk("full_retire_valid", retire_valid, 0);
    tick();
    chk("full_hold_count", count, 16);
    chk("full_alloc_tag_wrap", alloc_tag, 0);
    alloc_valid = 0;

    // Out-of-order completion, in-order retire; alloc alongside first retire
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_has_rd = (i != 1); alloc_pd_old = 7'(10 + i);
      tick();
    end
    alloc_valid = 0;
    alu_done = 1; alu_tag = 2;
    chk("ooo_no_ret_a", retire_valid, 0);
    tick();
    alu_done = 0; b_done = 1; b_tag = 1;
    chk("ooo_no_ret_b", retire_valid, 0);
    tick();
    b_done = 0; mem_done = 1; mem_tag = 0;
    chk("ooo_no_ret_c", retire_valid, 0);
    tick();
    mem_done = 0;
    chk("ooo_ret0_valid", retire_valid, 1);
    chk("ooo_ret0_tag", retire_tag, 0);
    chk("ooo_ret0_pd", retire_pd_old, 10);
    chk("ooo_ret0_hasrd", retire_has_rd, 1);
    alloc_valid = 1; alloc_has_rd = 0; alloc_pd_old = 7'd99;
    chk("ooo_alloc_tag3", alloc_tag, 3);
    tick();
    alloc_valid = 0;
    chk("ooo_alloc_ret_count", count, 3);
    chk("ooo_ret1_valid", retire_valid, 1);
    chk("ooo_ret1_tag", retire_tag, 1);
    chk("ooo_ret1_hasrd", retire_has_rd, 0);
    tick();
    chk("ooo_ret2_tag", retire_tag, 2);
    chk("ooo_ret2_pd", retire_pd_old, 12);
    tick();
    chk("ooo_end_valid", retire_valid, 0);
    chk("ooo_end_count", count, 1);

    // Triple completion
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1; alloc_has_rd = 1; alloc_pd_old = 7'(20 + i);
      tick();
    end
    alloc_valid = 0;
    alu_done = 1; alu_tag = 0; b_done = 1; b_tag = 1; mem_done = 1; mem_tag = 2;
    tick();
    chk("tri_ret0_tag", retire_tag, 0);
    chk("tri_ret0_valid", retire_valid, 1);
    alu_tag = 3; b_tag = 4; mem_tag = 5;
    tick();
    clear_inputs();
    chk("tri_count5", count, 5);
    for (int i = 1; i < 6; i++) begin
      chk("tri_ret_valid", retire_valid, 1);
      chk("tri_ret_tag", retire_tag, i);
      chk("tri_ret_pd", retire_pd_old, 20 + i);
      tick();
    end
    chk("tri_end_valid", retire_valid, 0);
    chk("tri_end_count", count, 0);

    // Mispredict: head=2, tail=10, branch tag 5
    do_reset();
    for (int i = 0; i < 10; i++) begin
      alloc_valid = 1; alloc_has_rd = 1; alloc_pd_old = 7'(30 + i);
      tick();
    end
    alloc_valid = 0;
    alu_done = 1; alu_tag = 0; b_done = 1; b_tag = 1;
    tick();
    clear_inputs();
    chk("mp_pre_ret0", retire_tag, 0);
    tick();
    chk("mp_pre_ret1", retire_tag, 1);
    tick();
    chk("mp_pre_count", count, 8);
    chk("mp_pre_valid", retire_valid, 0);
    mispredict = 1; mispredict_tag = 5;
    alu_done = 1; alu_tag = 7; b_done = 1; b_tag = 3;
    alloc_valid = 1;
    #1;
    chk("mp_alloc_ready", alloc_ready, 0);
    tick();
    clear_inputs();
    chk("mp_count", count, 4);
    chk("mp_alloc_tag", alloc_tag, 6);
    chk("mp_no_ret", retire_valid, 0);
    for (int i = 0; i < 2; i++) begin
      alloc_valid = 1; alloc_has_rd = 1; alloc_pd_old = 7'(50 + i);
      tick();
    end
    alloc_valid = 0;
    chk("mp_realloc_count", count, 6);
    chk("mp_realloc_tag", alloc_tag, 8);
    alu_done = 1; alu_tag = 2; b_done = 1; b_tag = 4; mem_done = 1; mem_tag = 5;
    tick();
    clear_inputs();
    alu_done = 1; alu_tag = 6;
    chk("mp_ret2", retire_tag, 2);
    chk("mp_ret2_pd", retire_pd_old, 32);
    tick();
    clear_inputs();
    chk("mp_ret3", retire_tag, 3);
    tick();
    chk("mp_ret4", retire_tag, 4);
    tick();
    chk("mp_ret5", retire_tag, 5);
    tick();
    chk("mp_ret6", retire_tag, 6);
    chk("mp_ret6_pd", retire_pd_old, 50);
    tick();
    chk("mp_tag7_not_done", retire_valid, 0);
    chk("mp_tail_count", count, 1);
    // Mispredict on an invalid tag is ignored
    mispredict = 1; mispredict_tag = 12;
    tick();
    clear_inputs();
    chk("mp_inv_count", count, 1);
    chk("mp_inv_alloc_tag", alloc_tag, 8);

    // Wrap-around: advance head to 14 then allocate 14,15,0,1
    do_reset();
    for (int i = 0; i < 14; i++) begin
      alloc_valid = 1; alloc_has_rd = 0; alloc_pd_old = '0;
      tick();
    end
    alloc_valid = 0;
    for (int i = 0; i < 14; i++) begin
      alu_done = 1; alu_tag = 4'(i);
      tick();
    end
    clear_inputs();
    tick();
    chk("wrap_drain_count", count, 0);
    chk("wrap_alloc_tag14", alloc_tag, 14);
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1; alloc_has_rd = 1; alloc_pd_old = 7'(60 + i);
      chk("wrap_alloc_tag", alloc_tag, (14 + i) % 16);
      tick();
    end
    alloc_valid = 0;
    chk("wrap_count4", count, 4);
    alu_done = 1; alu_tag = 14; b_done = 1; b_tag = 15; mem_done = 1; mem_tag = 0;
    tick();
    clear_inputs();
    alu_done = 1; alu_tag = 1;
    chk("wrap_ret14", retire_tag, 14);
    tick();
    clear_inputs();
    chk("wrap_ret15", retire_tag, 15);
    tick();
    chk("wrap_ret0", retire_tag, 0);
    chk("wrap_ret0_pd", retire_pd_old, 62);
    tick();
    chk("wrap_ret1", retire_tag, 1);
    chk("wrap_ret1_valid", retire_valid, 1);
    tick();
    chk("wrap_end_count", count, 0);
    chk("wrap_end_valid", retire_valid, 0);
`ifdef ROB_PERF_CNT_EN
    chk("perf_retired", retired_count, 18);
`endif

    // Asynchronous reset with 8 entries, some completed
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1; alloc_has_rd = 1; alloc_pd_old = 7'(i);
      tick();
    end
    alloc_valid = 0;
    alu_done = 1; alu_tag = 2;
    tick();
    clear_inputs();
    chk("mid_count8", count, 8);
    chk("mid_ret_valid", retire_valid, 1);
    reset = 0;
    #1;
    chk("async_count", count, 0);
    chk("async_retire_valid", retire_valid, 0);
    chk("async_alloc_tag", alloc_tag, 0);
`ifdef ROB_PERF_CNT_EN
    chk("async_perf", retired_count, 0);
`endif
    reset = 1;
    tick();
    chk("post_reset_ready", alloc_ready, 1);
    chk("post_reset_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
